// File: rtl/program_memory_if.sv
// CPU read/write bus plus byte-serial loader port for program_memory.
// The master side drives requests, the slave side is the memory.
interface program_memory_if #(
    parameter int unsigned DEPTH = 128,
    parameter int unsigned LEN_W = 8
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic        [AW-1:0]    Mem_Address;
    logic                    rd;
    logic                    wr;
    logic signed [15:0]      Data_Out;
    logic signed [15:0]      Mem_Data;

    logic                    ld_start;
    logic        [AW-1:0]    ld_base;
    logic        [LEN_W-1:0] ld_len;
    logic                    ld_valid;
    logic        [7:0]       ld_byte;
    logic                    ld_ready;
    logic                    ld_busy;
    logic                    ld_done;
    logic        [LEN_W-1:0] ld_count;

    modport master (
        output Mem_Address, rd, wr, Data_Out,
        output ld_start, ld_base, ld_len, ld_valid, ld_byte,
        input  Mem_Data, ld_ready, ld_busy, ld_done, ld_count
    );

    modport slave (
        input  Mem_Address, rd, wr, Data_Out,
        input  ld_start, ld_base, ld_len, ld_valid, ld_byte,
        output Mem_Data, ld_ready, ld_busy, ld_done, ld_count
    );
endinterface

// File: rtl/program_memory.sv
// Unified instruction/data memory with a registered CPU read port and a
// byte-serial loader that holds off the CPU while a program image is written.
module program_memory #(
    parameter int unsigned DEPTH = 128,
    parameter int unsigned LEN_W = 8
) (
    input logic             clk,
    input logic             rst,
    program_memory_if.slave bus
);
    localparam int unsigned AW = $clog2(DEPTH);

    typedef enum logic [1:0] {StIdle, StHi, StLo, StDone} state_e;

    // Contents intentionally survive reset.
    logic signed [15:0]      r_mem [DEPTH];
    logic signed [15:0]      r_mem_data;

    state_e                  r_state;
    logic        [AW-1:0]    r_waddr;
    logic        [LEN_W-1:0] r_remain;
    logic        [7:0]       r_hi;
    logic        [LEN_W-1:0] r_count;

    state_e                  w_state_next;
    logic        [AW-1:0]    w_waddr_next;
    logic        [LEN_W-1:0] w_remain_next;
    logic        [7:0]       w_hi_next;
    logic        [LEN_W-1:0] w_count_next;
    logic                    w_ld_we;

    logic                    w_busy;
    logic                    w_cpu_we;
    logic                    w_cpu_re;
    logic                    w_mem_we;
    logic        [AW-1:0]    w_mem_addr;
    logic signed [15:0]      w_mem_wdata;

    assign w_busy   = (r_state != StIdle);
    assign w_cpu_we = !w_busy && bus.wr;
    assign w_cpu_re = !w_busy && bus.rd && !bus.wr;

    always_comb begin
        w_state_next  = r_state;
        w_waddr_next  = r_waddr;
        w_remain_next = r_remain;
        w_hi_next     = r_hi;
        w_count_next  = r_count;
        w_ld_we       = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (bus.ld_start) begin
                    w_waddr_next  = bus.ld_base;
                    w_remain_next = bus.ld_len;
                    w_count_next  = '0;
                    w_state_next  = (bus.ld_len == '0) ? StDone : StHi;
                end
            end
            StHi: begin
                if (bus.ld_valid) begin
                    w_hi_next    = bus.ld_byte;
                    w_state_next = StLo;
                end
            end
            StLo: begin
                if (bus.ld_valid) begin
                    w_ld_we       = 1'b1;
                    w_waddr_next  = r_waddr + AW'(1);
                    w_count_next  = r_count + LEN_W'(1);
                    w_remain_next = r_remain - LEN_W'(1);
                    w_state_next  = (r_remain == LEN_W'(1)) ? StDone : StHi;
                end
            end
            StDone: begin
                w_state_next = StIdle;
            end
            default: begin
                w_state_next = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= StIdle;
            r_waddr  <= '0;
            r_remain <= '0;
            r_hi     <= '0;
            r_count  <= '0;
        end else begin
            r_state  <= w_state_next;
            r_waddr  <= w_waddr_next;
            r_remain <= w_remain_next;
            r_hi     <= w_hi_next;
            r_count  <= w_count_next;
        end
    end

    // Loader and CPU writes never overlap: CPU writes are only taken when idle.
    assign w_mem_we    = (w_ld_we && !rst) || w_cpu_we;
    assign w_mem_addr  = w_ld_we ? r_waddr : bus.Mem_Address;
    assign w_mem_wdata = w_ld_we ? {r_hi, bus.ld_byte} : bus.Data_Out;

    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[w_mem_addr] <= w_mem_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mem_data <= '0;
        end else if (w_cpu_re) begin
            r_mem_data <= r_mem[bus.Mem_Address];
        end
    end

    assign bus.Mem_Data = r_mem_data;
    assign bus.ld_ready = (r_state == StHi) || (r_state == StLo);
    assign bus.ld_busy  = w_busy;
    assign bus.ld_done  = (r_state == StDone);
    assign bus.ld_count = r_count;
endmodule

// File: tb/tb_program_memory.sv
// Directed bench for program_memory: CPU read/write, loader, wrap, blocking,
// zero-length load and reset mid-load.
module tb_program_memory;
    logic clk;
    logic rst;
    int   n_pass;
    int   n_total;

    program_memory_if #(.DEPTH(128), .LEN_W(8)) bus ();

    program_memory #(.DEPTH(128), .LEN_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cpu_write(input logic [6:0] addr, input logic [15:0] data);
        bus.Mem_Address = addr;
        bus.Data_Out    = data;
        bus.wr          = 1'b1;
        tick();
        bus.wr          = 1'b0;
    endtask

    task automatic cpu_read(input logic [6:0] addr);
        bus.Mem_Address = addr;
        bus.rd          = 1'b1;
        tick();
        bus.rd          = 1'b0;
    endtask

    task automatic start_load(input logic [6:0] base, input logic [7:0] len);
        bus.ld_base  = base;
        bus.ld_len   = len;
        bus.ld_start = 1'b1;
        tick();
        bus.ld_start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        n_total++;
        if (bus.Mem_Data !== 16'h0000) $display("FAIL reset_mem_data: got %h want 0000", bus.Mem_Data);
        else n_pass++;
        n_total++;
        if (bus.ld_ready !== 1'b0) $display("FAIL reset_ready: got %b want 0", bus.ld_ready);
        else n_pass++;
        n_total++;
        if (bus.ld_busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", bus.ld_busy);
        else n_pass++;
        n_total++;
        if (bus.ld_done !== 1'b0) $display("FAIL reset_done: got %b want 0", bus.ld_done);
        else n_pass++;
        n_total++;
        if (bus.ld_count !== 8'd0) $display("FAIL reset_count: got %0d want 0", bus.ld_count);
        else n_pass++;
    endtask

    task automatic test_cpu_rw();
        cpu_write(7'd5, 16'h1234);
        n_total++;
        if (bus.Mem_Data !== 16'h0000) $display("FAIL cpu_wr_hold: got %h want 0000", bus.Mem_Data);
        else n_pass++;
        cpu_read(7'd5);
        n_total++;
        if (bus.Mem_Data !== 16'h1234) $display("FAIL cpu_rd5: got %h want 1234", bus.Mem_Data);
        else n_pass++;
        // rd and wr together: write lands, read data holds
        bus.rd = 1'b1;
        cpu_write(7'd6, 16'h5555);
        bus.rd = 1'b0;
        n_total++;
        if (bus.Mem_Data !== 16'h1234) $display("FAIL cpu_rdwr_hold: got %h want 1234", bus.Mem_Data);
        else n_pass++;
        cpu_read(7'd6);
        n_total++;
        if (bus.Mem_Data !== 16'h5555) $display("FAIL cpu_rd6: got %h want 5555", bus.Mem_Data);
        else n_pass++;
    endtask

    task automatic test_load_basic();
        logic [7:0] bytes [6];
        int         early_done;
        bytes = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC};
        early_done = 0;
        start_load(7'd0, 8'd3);
        n_total++;
        if (bus.ld_busy !== 1'b1 || bus.ld_ready !== 1'b1)
            $display("FAIL load_start: busy=%b ready=%b want 1 1", bus.ld_busy, bus.ld_ready);
        else n_pass++;
        for (int i = 0; i < 6; i++) begin
            bus.ld_valid = 1'b1;
            bus.ld_byte  = bytes[i];
            tick();
            if (i < 5 && bus.ld_done === 1'b1) early_done++;
        end
        bus.ld_valid = 1'b0;
        n_total++;
        if (early_done != 0) $display("FAIL load_early_done: got %0d pulses want 0", early_done);
        else n_pass++;
        n_total++;
        if (bus.ld_done !== 1'b1 || bus.ld_busy !== 1'b1)
            $display("FAIL load_done: done=%b busy=%b want 1 1", bus.ld_done, bus.ld_busy);
        else n_pass++;
        n_total++;
        if (bus.ld_count !== 8'd3) $display("FAIL load_count: got %0d want 3", bus.ld_count);
        else n_pass++;
        tick();
        n_total++;
        if (bus.ld_done !== 1'b0 || bus.ld_busy !== 1'b0)
            $display("FAIL load_end: done=%b busy=%b want 0 0", bus.ld_done, bus.ld_busy);
        else n_pass++;
        cpu_read(7'd0);
        n_total++;
        if (bus.Mem_Data !== 16'h1234) $display("FAIL load_mem0: got %h want 1234", bus.Mem_Data);
        else n_pass++;
        cpu_read(7'd1);
        n_total++;
        if (bus.Mem_Data !== 16'h5678) $display("FAIL load_mem1: got %h want 5678", bus.Mem_Data);
        else n_pass++;
        cpu_read(7'd2);
        n_total++;
        if (bus.Mem_Data !== 16'h9ABC) $display("FAIL load_mem2: got %h want 9abc", bus.Mem_Data);
        else n_pass++;
    endtask

    task automatic test_wrap_stall();
        logic [7:0] bytes [4];
        bytes = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
        start_load(7'd127, 8'd2);
        for (int i = 0; i < 7; i++) begin
            bus.ld_valid = (i % 2 == 0);
            bus.ld_byte  = (i % 2 == 0) ? bytes[i / 2] : 8'hEE;
            tick();
            if (i == 1) begin
                n_total++;
                if (bus.ld_ready !== 1'b1 || bus.ld_count !== 8'd0)
                    $display("FAIL wrap_stall_hi: ready=%b count=%0d want 1 0",
                             bus.ld_ready, bus.ld_count);
                else n_pass++;
            end
            if (i == 3) begin
                n_total++;
                if (bus.ld_count !== 8'd1 || bus.ld_busy !== 1'b1)
                    $display("FAIL wrap_stall_lo: count=%0d busy=%b want 1 1",
                             bus.ld_count, bus.ld_busy);
                else n_pass++;
            end
        end
        bus.ld_valid = 1'b0;
        n_total++;
        if (bus.ld_done !== 1'b1 || bus.ld_count !== 8'd2)
            $display("FAIL wrap_done: done=%b count=%0d want 1 2", bus.ld_done, bus.ld_count);
        else n_pass++;
        tick();
        cpu_read(7'd127);
        n_total++;
        if (bus.Mem_Data !== 16'hAABB) $display("FAIL wrap_mem127: got %h want aabb", bus.Mem_Data);
        else n_pass++;
        cpu_read(7'd0);
        n_total++;
        if (bus.Mem_Data !== 16'hCCDD) $display("FAIL wrap_mem0: got %h want ccdd", bus.Mem_Data);
        else n_pass++;
    endtask

    task automatic test_blocked();
        cpu_write(7'd10, 16'h0A0A);
        cpu_read(7'd10);
        start_load(7'd20, 8'd1);
        bus.Mem_Address = 7'd10;
        bus.Data_Out    = 16'hFFFF;
        bus.wr          = 1'b1;
        bus.rd          = 1'b1;
        bus.ld_start    = 1'b1;
        bus.ld_base     = 7'd30;
        bus.ld_len      = 8'd5;
        bus.ld_valid    = 1'b1;
        bus.ld_byte     = 8'h11;
        tick();
        bus.ld_byte     = 8'h22;
        tick();
        bus.wr          = 1'b0;
        bus.rd          = 1'b0;
        bus.ld_start    = 1'b0;
        bus.ld_valid    = 1'b0;
        n_total++;
        if (bus.Mem_Data !== 16'h0A0A) $display("FAIL blk_hold: got %h want 0a0a", bus.Mem_Data);
        else n_pass++;
        n_total++;
        if (bus.ld_done !== 1'b1 || bus.ld_count !== 8'd1)
            $display("FAIL blk_no_restart: done=%b count=%0d want 1 1", bus.ld_done, bus.ld_count);
        else n_pass++;
        tick();
        n_total++;
        if (bus.ld_busy !== 1'b0) $display("FAIL blk_idle: busy=%b want 0", bus.ld_busy);
        else n_pass++;
        cpu_read(7'd20);
        n_total++;
        if (bus.Mem_Data !== 16'h1122) $display("FAIL blk_mem20: got %h want 1122", bus.Mem_Data);
        else n_pass++;
        cpu_read(7'd10);
        n_total++;
        if (bus.Mem_Data !== 16'h0A0A) $display("FAIL blk_mem10: got %h want 0a0a", bus.Mem_Data);
        else n_pass++;
    endtask

    task automatic test_zero_len();
        start_load(7'd20, 8'd0);
        n_total++;
        if (bus.ld_busy !== 1'b1 || bus.ld_done !== 1'b1 || bus.ld_ready !== 1'b0)
            $display("FAIL zero_done: busy=%b done=%b ready=%b want 1 1 0",
                     bus.ld_busy, bus.ld_done, bus.ld_ready);
        else n_pass++;
        n_total++;
        if (bus.ld_count !== 8'd0) $display("FAIL zero_count: got %0d want 0", bus.ld_count);
        else n_pass++;
        tick();
        n_total++;
        if (bus.ld_busy !== 1'b0 || bus.ld_done !== 1'b0)
            $display("FAIL zero_end: busy=%b done=%b want 0 0", bus.ld_busy, bus.ld_done);
        else n_pass++;
        cpu_read(7'd20);
        n_total++;
        if (bus.Mem_Data !== 16'h1122) $display("FAIL zero_mem20: got %h want 1122", bus.Mem_Data);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        logic [7:0] bytes [3];
        bytes = '{8'h01, 8'h02, 8'h03};
        cpu_write(7'd41, 16'h4141);
        start_load(7'd40, 8'd4);
        for (int i = 0; i < 3; i++) begin
            bus.ld_valid = 1'b1;
            bus.ld_byte  = bytes[i];
            tick();
        end
        n_total++;
        if (bus.ld_count !== 8'd1) $display("FAIL rstmid_count: got %0d want 1", bus.ld_count);
        else n_pass++;
        bus.ld_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_total++;
        if (bus.ld_busy !== 1'b0 || bus.ld_ready !== 1'b0 || bus.ld_done !== 1'b0)
            $display("FAIL rstmid_idle: busy=%b ready=%b done=%b want 0 0 0",
                     bus.ld_busy, bus.ld_ready, bus.ld_done);
        else n_pass++;
        n_total++;
        if (bus.ld_count !== 8'd0 || bus.Mem_Data !== 16'h0000)
            $display("FAIL rstmid_regs: count=%0d data=%h want 0 0000", bus.ld_count, bus.Mem_Data);
        else n_pass++;
        cpu_read(7'd40);
        n_total++;
        if (bus.Mem_Data !== 16'h0102) $display("FAIL rstmid_mem40: got %h want 0102", bus.Mem_Data);
        else n_pass++;
        cpu_read(7'd41);
        n_total++;
        if (bus.Mem_Data !== 16'h4141) $display("FAIL rstmid_mem41: got %h want 4141", bus.Mem_Data);
        else n_pass++;
    endtask

    initial begin
        n_pass          = 0;
        n_total         = 0;
        rst             = 1'b1;
        bus.Mem_Address = '0;
        bus.rd          = 1'b0;
        bus.wr          = 1'b0;
        bus.Data_Out    = '0;
        bus.ld_start    = 1'b0;
        bus.ld_base     = '0;
        bus.ld_len      = '0;
        bus.ld_valid    = 1'b0;
        bus.ld_byte     = '0;
        test_reset();
        test_cpu_rw();
        test_load_basic();
        test_wrap_stall();
        test_blocked();
        test_zero_len();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
